red_pitaya_na_sweep_block: RTL and testbench

Network-analyzer sweep sequencer that sits directly downstream of the IQ demodulator/low-pass stage. It steps the IQ reference frequency through a programmed list of points. At each point it waits a settling time, then accumulates the low-passed quadratures for a programmed number of cycles. Per-point I/Q sums go into an on-chip result buffer, which the PS reads after the sweep, so no CPU round-trip is needed per frequency point.

---
 rtl/red_pitaya_na_sweep_block.sv | 242 ++++++++++++++++++++++++
 tb/tb_red_pitaya_na_sweep_block.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_na_sweep_block.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_na_sweep_block
//  Function : Network-analyzer sweep sequencer. Steps the IQ reference
//             frequency through a list of points. At each point it waits a
//             settling time, then integrates the low-passed quadratures.
//             Per-point I/Q sums are written to an on-chip result buffer
//             that the PS reads over the bus.
//  Options  : NA_SWEEP_OVF_FLAG_EN - sticky signed-overflow detector on
//             both accumulators, reported in status bit 31.
//  Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_na_sweep_block #(
    parameter int LPFBITS   = 24,
    parameter int PHASEBITS = 32,
    parameter int SUMBITS   = 48,
    parameter int DEPTHLOG  = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [LPFBITS-1:0]   quad1_i,
    input  logic signed [LPFBITS-1:0]   quad2_i,
    output logic [PHASEBITS-1:0]        freq_o,
    output logic                        freq_update_o,
    output logic                        busy_o,
    output logic                        done_o,
    input  logic [15:0]                 addr,
    input  logic                        wen,
    input  logic                        ren,
    output logic                        ack,
    output logic [31:0]                 rdata,
    input  logic [31:0]                 wdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETFREQ = 3'd1,
        S_SLEEP   = 3'd2,
        S_ACCUM   = 3'd3,
        S_STORE   = 3'd4
    } state_t;

    localparam int          c_NPTS    = 1 << DEPTHLOG;
    localparam logic [31:0] c_NPTS_W  = 32'(c_NPTS);
    localparam logic [31:0] c_BUF_END = 32'h0000_1000 + (c_NPTS_W << 4);

    state_t                     r_state, w_state_nxt;
    logic [31:0]                r_start_freq, r_step_freq, r_points, r_averages, r_sleep;
    logic [PHASEBITS-1:0]       r_freq;
    logic [15:0]                r_index;
    logic [31:0]                r_scnt, r_acnt;
    logic signed [SUMBITS-1:0]  r_sum_i, r_sum_q;
    logic                       r_done;
    logic [SUMBITS-1:0]         r_mem_i [c_NPTS];
    logic [SUMBITS-1:0]         r_mem_q [c_NPTS];

    logic                       w_ctrl_wr, w_start, w_abort;
    logic [31:0]                w_pts_eff, w_avg_eff;
    logic                       w_last_pt, w_last_smp;
    logic signed [SUMBITS-1:0]  w_q1_ext, w_q2_ext, w_sum_i_nxt, w_sum_q_nxt;
    logic                       w_ovf_flag;
    logic                       w_in_buf;
    logic [DEPTHLOG-1:0]        w_rd_idx;
    logic [SUMBITS-1:0]         w_mi, w_mq;
    logic [63:0]                w_buf_i, w_buf_q;
    logic [31:0]                w_rd_data;

    // A start only takes effect from IDLE; abort has priority over start.
    assign w_ctrl_wr = wen && (addr == 16'h0000);
    assign w_abort   = w_ctrl_wr && wdata[1] && (r_state != S_IDLE);
    assign w_start   = w_ctrl_wr && wdata[0] && !wdata[1] && (r_state == S_IDLE);

    // Zero counts behave as one; point count saturates at buffer depth.
    assign w_pts_eff  = (r_points == 32'd0) ? 32'd1 :
                        (r_points > c_NPTS_W) ? c_NPTS_W : r_points;
    assign w_avg_eff  = (r_averages == 32'd0) ? 32'd1 : r_averages;
    assign w_last_pt  = ({16'd0, r_index} + 32'd1) == w_pts_eff;
    assign w_last_smp = (r_acnt + 32'd1) == w_avg_eff;

    assign w_q1_ext    = {{(SUMBITS-LPFBITS){quad1_i[LPFBITS-1]}}, quad1_i};
    assign w_q2_ext    = {{(SUMBITS-LPFBITS){quad2_i[LPFBITS-1]}}, quad2_i};
    assign w_sum_i_nxt = r_sum_i + w_q1_ext;
    assign w_sum_q_nxt = r_sum_q + w_q2_ext;

    assign freq_o        = r_freq;
    assign freq_update_o = (r_state == S_SETFREQ);
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides any sequencing step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_state_nxt = S_SETFREQ;
            S_SETFREQ: w_state_nxt = S_SLEEP;
            S_SLEEP:   if (r_scnt <= 32'd1) w_state_nxt = S_ACCUM;
            S_ACCUM:   if (w_last_smp) w_state_nxt = S_STORE;
            S_STORE:   w_state_nxt = w_last_pt ? S_IDLE : S_SETFREQ;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // Sweep datapath: frequency, counters, accumulators, done flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_freq  <= '0;
            r_index <= '0;
            r_scnt  <= '0;
            r_acnt  <= '0;
            r_sum_i <= '0;
            r_sum_q <= '0;
            r_done  <= 1'b0;
        end else if (w_start) begin
            r_done  <= 1'b0;
            r_freq  <= r_start_freq[PHASEBITS-1:0];
            r_index <= '0;
        end else if (!w_abort) begin
            case (r_state)
                S_SETFREQ: begin
                    r_scnt  <= r_sleep;
                    r_acnt  <= '0;
                    r_sum_i <= '0;
                    r_sum_q <= '0;
                end
                S_SLEEP: begin
                    if (r_scnt != 32'd0) r_scnt <= r_scnt - 32'd1;
                end
                S_ACCUM: begin
                    r_sum_i <= w_sum_i_nxt;
                    r_sum_q <= w_sum_q_nxt;
                    r_acnt  <= r_acnt + 32'd1;
                end
                S_STORE: begin
                    r_index <= r_index + 16'd1;
                    if (w_last_pt) r_done <= 1'b1;
                    else           r_freq <= r_freq + r_step_freq[PHASEBITS-1:0];
                end
                default: ;
            endcase
        end
    end

`ifdef NA_SWEEP_OVF_FLAG_EN
    logic r_ovf;
    logic w_ovf_i, w_ovf_q;
    // Signed overflow: operands agree in sign but the result does not
    assign w_ovf_i = (r_sum_i[SUMBITS-1] == w_q1_ext[SUMBITS-1]) &&
                     (w_sum_i_nxt[SUMBITS-1] != r_sum_i[SUMBITS-1]);
    assign w_ovf_q = (r_sum_q[SUMBITS-1] == w_q2_ext[SUMBITS-1]) &&
                     (w_sum_q_nxt[SUMBITS-1] != r_sum_q[SUMBITS-1]);

    // Sticky overflow flag, cleared by a new sweep
    always_ff @(posedge clk_i) begin
        if (rst_i)                                  r_ovf <= 1'b0;
        else if (w_start)                           r_ovf <= 1'b0;
        else if (r_state == S_ACCUM && !w_abort &&
                 (w_ovf_i || w_ovf_q))              r_ovf <= 1'b1;
    end
    assign w_ovf_flag = r_ovf;
`else
    assign w_ovf_flag = 1'b0;
`endif

    // Result buffer write; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (r_state == S_STORE && !w_abort) begin
            r_mem_i[r_index[DEPTHLOG-1:0]] <= r_sum_i;
            r_mem_q[r_index[DEPTHLOG-1:0]] <= r_sum_q;
        end
    end

    // Configuration registers; frozen while a sweep runs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_start_freq <= '0;
            r_step_freq  <= '0;
            r_points     <= '0;
            r_averages   <= '0;
            r_sleep      <= '0;
        end else if (wen && r_state == S_IDLE) begin
            case (addr)
                16'h0004: r_start_freq <= wdata;
                16'h0008: r_step_freq  <= wdata;
                16'h000C: r_points     <= wdata;
                16'h0010: r_averages   <= wdata;
                16'h0014: r_sleep      <= wdata;
                default: ;
            endcase
        end
    end

    assign w_in_buf = ({16'd0, addr} >= 32'h0000_1000) && ({16'd0, addr} < c_BUF_END);
    assign w_rd_idx = addr[DEPTHLOG+3:4];

    // Read-data mux over registers and result buffer
    always_comb begin
        w_rd_data = '0;
        w_mi      = r_mem_i[w_rd_idx];
        w_mq      = r_mem_q[w_rd_idx];
        w_buf_i   = {{(64-SUMBITS){w_mi[SUMBITS-1]}}, w_mi};
        w_buf_q   = {{(64-SUMBITS){w_mq[SUMBITS-1]}}, w_mq};
        if (w_in_buf) begin
            case (addr[3:2])
                2'd0: w_rd_data = w_buf_i[31:0];
                2'd1: w_rd_data = w_buf_i[63:32];
                2'd2: w_rd_data = w_buf_q[31:0];
                default: w_rd_data = w_buf_q[63:32];
            endcase
        end else begin
            case (addr)
                16'h0004: w_rd_data = r_start_freq;
                16'h0008: w_rd_data = r_step_freq;
                16'h000C: w_rd_data = r_points;
                16'h0010: w_rd_data = r_averages;
                16'h0014: w_rd_data = r_sleep;
                16'h0018: w_rd_data = {w_ovf_flag, 13'd0, r_done, busy_o, r_index};
                16'h001C: w_rd_data = {16'd0, r_index};
                default:  w_rd_data = '0;
            endcase
        end
    end

    // Registered bus response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= wen || ren;
            rdata <= ren ? w_rd_data : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_na_sweep_block.sv
`default_nettype none
// ============================================================================
//  Module   : tb_red_pitaya_na_sweep_block
//  Function : Scoreboard bench for the NA sweep sequencer. Bus reads and
//             frequency steps push expected values into queues; monitors
//             pop and compare when ack / freq_update_o appear.
//             Accumulator width is reduced so overflow is reachable quickly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_na_sweep_block;

    localparam int SB = 28;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] quad1, quad2;
    logic [31:0]        freq;
    logic               freq_upd, busy, done;
    logic [15:0]        addr;
    logic               wen, ren, ack;
    logic [31:0]        rdata, wdata;

    red_pitaya_na_sweep_block #(
        .LPFBITS(24), .PHASEBITS(32), .SUMBITS(SB), .DEPTHLOG(6)
    ) dut (
        .clk_i(clk), .rst_i(rst), .quad1_i(quad1), .quad2_i(quad2),
        .freq_o(freq), .freq_update_o(freq_upd), .busy_o(busy), .done_o(done),
        .addr(addr), .wen(wen), .ren(ren), .ack(ack), .rdata(rdata), .wdata(wdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_exp_q[$];
    bit          rd_chk_q[$];
    string       rd_name_q[$];
    logic [31:0] fq_q[$];

`ifdef NA_SWEEP_OVF_FLAG_EN
    localparam logic [31:0] OVF_BIT = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_BIT = 32'h0000_0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus monitor: every ack retires one queued transaction
    logic [31:0] m_exp;
    bit          m_chk;
    string       m_name;
    always @(negedge clk) begin
        if (ack) begin
            if (rd_chk_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL bus_ack: unexpected ack, rdata 0x%08h", rdata);
            end else begin
                m_exp  = rd_exp_q.pop_front();
                m_chk  = rd_chk_q.pop_front();
                m_name = rd_name_q.pop_front();
                if (m_chk) check(m_name, rdata, m_exp);
            end
        end
        if (freq_upd) begin
            if (fq_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL freq_update: unexpected pulse, freq 0x%08h", freq);
            end else begin
                check("freq_step", freq, fq_q.pop_front());
            end
        end
    end

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        rd_exp_q.push_back(32'd0); rd_chk_q.push_back(1'b0); rd_name_q.push_back("wr");
        @(negedge clk);
        addr = a; wdata = d; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp); rd_chk_q.push_back(1'b1); rd_name_q.push_back(name);
        @(negedge clk);
        addr = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic config_sweep(input logic [31:0] f0, input logic [31:0] st,
                                input logic [31:0] pts, input logic [31:0] avg,
                                input logic [31:0] slp);
        bus_wr(16'h0004, f0);
        bus_wr(16'h0008, st);
        bus_wr(16'h000C, pts);
        bus_wr(16'h0010, avg);
        bus_wr(16'h0014, slp);
    endtask

    // Counts negedges with busy high, bounded
    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 2000) begin
            t++;
            @(negedge clk);
        end
        check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_buf(input int k, input logic [31:0] il, input logic [31:0] ih,
                           input logic [31:0] ql, input logic [31:0] qh);
        logic [15:0] b;
        b = 16'h1000 + 16'(k * 16);
        bus_rd(b,          il, $sformatf("buf%0d_I_lo", k));
        bus_rd(b + 16'h4,  ih, $sformatf("buf%0d_I_hi", k));
        bus_rd(b + 16'h8,  ql, $sformatf("buf%0d_Q_lo", k));
        bus_rd(b + 16'hC,  qh, $sformatf("buf%0d_Q_hi", k));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, t;
        rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
        quad1 = '0; quad2 = '0;
        repeat (3) @(negedge clk);
        check("rst_freq", freq, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        rst = 1'b0;
        bus_rd(16'h0018, 32'd0, "rst_status");
        bus_rd(16'h000C, 32'd0, "rst_points");

        // Three-point sweep, constant inputs
        quad1 = 24'sd100; quad2 = -24'sd7;
        config_sweep(32'd1000, 32'd500, 32'd3, 32'd4, 32'd2);
        fq_q.push_back(32'd1000); fq_q.push_back(32'd1500); fq_q.push_back(32'd2000);
        bus_wr(16'h0000, 32'd1);
        count_busy(cyc);
        check("sweep1_busy_cycles", 32'(cyc), 32'd24);
        check("sweep1_done_pin", {31'd0, done}, 32'd1);
        bus_rd(16'h0018, 32'h0002_0003, "sweep1_status");
        bus_rd(16'h001C, 32'd3, "sweep1_count");
        for (int k = 0; k < 3; k++) chk_buf(k, 32'd400, 32'd0, 32'hFFFF_FFE4, 32'hFFFF_FFFF);
        bus_rd(16'h0000, 32'd0, "ctrl_reads0");

        // Degenerate config: every count is zero
        quad1 = 24'sd5; quad2 = 24'sd3;
        config_sweep(32'd77, 32'd1, 32'd0, 32'd0, 32'd0);
        fq_q.push_back(32'd77);
        bus_wr(16'h0000, 32'd1);
        count_busy(cyc);
        check("zero_cfg_busy_cycles", 32'(cyc), 32'd4);
        bus_rd(16'h001C, 32'd1, "zero_cfg_count");
        chk_buf(0, 32'd5, 32'd0, 32'd3, 32'd0);
        bus_rd(16'h1010, 32'd400, "buf1_persist");

        // Phase-increment wrap
        config_sweep(32'hFFFF_FF00, 32'h0000_0200, 32'd2, 32'd1, 32'd0);
        fq_q.push_back(32'hFFFF_FF00); fq_q.push_back(32'h0000_0100);
        bus_wr(16'h0000, 32'd1);
        wait_idle("wrap");
        check("wrap_freq_final", freq, 32'h0000_0100);

        // Abort after the second frequency step
        quad1 = 24'sd11; quad2 = -24'sd2;
        config_sweep(32'd2000, 32'd100, 32'd10, 32'd3, 32'd1);
        fq_q.push_back(32'd2000); fq_q.push_back(32'd2100);
        bus_wr(16'h0000, 32'd1);
        n = 0; t = 0;
        while (n < 2 && t < 500) begin
            if (freq_upd) n++;
            if (n < 2) @(negedge clk);
            t++;
        end
        check("abort_saw_two_steps", 32'(n), 32'd2);
        bus_wr(16'h0000, 32'd3);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        check("abort_freq_hold", freq, 32'd2100);
        bus_rd(16'h001C, 32'd1, "abort_count");
        bus_rd(16'h0018, 32'h0000_0001, "abort_status");
        chk_buf(0, 32'd33, 32'd0, 32'hFFFF_FFFA, 32'hFFFF_FFFF);

        // Start and config writes while busy are ignored
        config_sweep(32'd50, 32'd10, 32'd2, 32'd4, 32'd3);
        fq_q.push_back(32'd50); fq_q.push_back(32'd60);
        bus_wr(16'h0000, 32'd1);
        bus_wr(16'h0000, 32'd1);
        bus_wr(16'h000C, 32'd7);
        bus_wr(16'h0004, 32'd999);
        wait_idle("busy_ign");
        bus_rd(16'h000C, 32'd2, "busy_ign_points");
        bus_rd(16'h0004, 32'd50, "busy_ign_start");
        bus_rd(16'h001C, 32'd2, "busy_ign_count");

        // Accumulator overflow
        quad1 = 24'sd8388607; quad2 = 24'sd0;
        config_sweep(32'd5, 32'd0, 32'd1, 32'd20, 32'd0);
        fq_q.push_back(32'd5);
        bus_wr(16'h0000, 32'd1);
        wait_idle("ovf");
        bus_rd(16'h0018, OVF_BIT | 32'h0002_0001, "ovf_status");

        // Unmapped address reads zero
        bus_rd(16'h0800, 32'd0, "unmapped");
        bus_rd(16'h1400, 32'd0, "beyond_buf");

        // Reset in the middle of a sweep
        quad1 = 24'sd1; quad2 = 24'sd1;
        config_sweep(32'd300, 32'd10, 32'd5, 32'd8, 32'd0);
        fq_q.push_back(32'd300);
        bus_wr(16'h0000, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_freq", freq, 32'd0);
        check("midrst_freq_upd", {31'd0, freq_upd}, 32'd0);
        rst = 1'b0;
        bus_rd(16'h000C, 32'd0, "midrst_points");
        bus_rd(16'h0018, 32'd0, "midrst_status");

        repeat (4) @(negedge clk);
        check("rd_queue_drained", 32'(rd_chk_q.size()), 32'd0);
        check("freq_queue_drained", 32'(fq_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
